// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: datapath width, PC step, default vectors
// and the sequencer state encoding.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
  localparam logic [XLEN-1:0] ALIGN_MASK           = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_WAIT_MEM = 2'd2,
    ST_TRAP     = 2'd3
  } pc_state_e;

  // Fetch addresses are word aligned; the low two bits are simply dropped.
  function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] t);
    return t & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC select: fixed-priority redirect arbitration,
// target alignment and the misalignment indication.
module pc_next_mux
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
  input  logic            active,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] epc,
  input  logic            trap_req,
  input  logic            trap_ret,
  input  logic            jmp_valid,
  input  logic [XLEN-1:0] jmp_target,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            stall,
  input  logic            imem_ready,
  output logic [XLEN-1:0] next_pc,
  output logic            redirect,
  output logic            trap_take,
  output logic            misalign
);

  logic [XLEN-1:0] target_s;

  always_comb begin
    target_s  = pc;
    redirect  = 1'b0;
    trap_take = 1'b0;
    if (active) begin
      if (trap_req) begin
        target_s  = TRAP_VECTOR;
        redirect  = 1'b1;
        trap_take = 1'b1;
      end else if (trap_ret) begin
        target_s = epc;
        redirect = 1'b1;
      end else if (jmp_valid) begin
        target_s = jmp_target;
        redirect = 1'b1;
      end else if (br_taken) begin
        target_s = br_target;
        redirect = 1'b1;
      end else begin
        target_s = pc;
      end
    end else begin
      target_s = pc;
    end

    // Redirects beat both Stall and a busy memory; sequential advance needs both clear.
    if (redirect) begin
      next_pc = align_target(target_s);
    end else if (active && !stall && imem_ready) begin
      next_pc = pc + PC_STEP;
    end else begin
      next_pc = pc;
    end

    misalign = redirect & target_s[1];
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter owner: BOOT/RUN/WAIT_MEM/TRAP sequencing,
// PC and EPC registers, fetch-valid and flush generation.
module pc_sequencer
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Stall,
  input  logic            Br_Taken,
  input  logic [XLEN-1:0] Br_Target,
  input  logic            Jmp_Valid,
  input  logic [XLEN-1:0] Jmp_Target,
  input  logic            Trap_Req,
  input  logic            Trap_Ret,
  input  logic            IMem_Ready,
  output logic [XLEN-1:0] PC_Out,
  output logic            Fetch_Valid,
  output logic            Flush,
  output logic [XLEN-1:0] EPC_Out,
  output logic            Misalign
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            active_s;
  logic [XLEN-1:0] next_pc_s;
  logic            redirect_s;
  logic            trap_take_s;
  logic            misalign_s;

  assign active_s = (state_q == ST_RUN) || (state_q == ST_WAIT_MEM);

  pc_next_mux #(
    .TRAP_VECTOR(TRAP_VECTOR)
  ) u_next_mux (
    .active    (active_s),
    .pc        (pc_q),
    .epc       (epc_q),
    .trap_req  (Trap_Req),
    .trap_ret  (Trap_Ret),
    .jmp_valid (Jmp_Valid),
    .jmp_target(Jmp_Target),
    .br_taken  (Br_Taken),
    .br_target (Br_Target),
    .stall     (Stall),
    .imem_ready(IMem_Ready),
    .next_pc   (next_pc_s),
    .redirect  (redirect_s),
    .trap_take (trap_take_s),
    .misalign  (misalign_s)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = next_pc_s;
    epc_d   = trap_take_s ? pc_q : epc_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN, ST_WAIT_MEM: begin
        if (trap_take_s) begin
          state_d = ST_TRAP;
        end else if (redirect_s || IMem_Ready) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_WAIT_MEM;
        end
      end
      ST_TRAP: state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      epc_q   <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
    end
  end

  // Flush and Misalign accompany the redirect in the cycle it is sampled.
  assign PC_Out      = pc_q;
  assign EPC_Out     = epc_q;
  assign Fetch_Valid = active_s;
  assign Flush       = redirect_s;
  assign Misalign    = misalign_s;

endmodule
